// File: rtl/candle_pkg.sv
// Shared constants and types for the candle bank controller and its per-candle slots.
package candle_pkg;

  localparam int DEFAULT_NUM_CANDLES = 8;
  localparam int DEFAULT_BURN_W      = 8;

  // When set and clear target the same candle in one cycle, the clear is applied
  // and the candle ends unlit.
  localparam bit CMD_CLEAR_PRIORITY = 1'b1;

  // Status of one slot at the default timer width.
  typedef struct packed {
    logic                      lit;
    logic [DEFAULT_BURN_W-1:0] timer;
  } slot_status_t;

endpackage

// File: rtl/candle_bank_controller_if.sv
// Command and status bundle between the command decoder and the candle bank.
interface candle_bank_controller_if
  import candle_pkg::*;
#(
  parameter int NUM_CANDLES = DEFAULT_NUM_CANDLES,
  parameter int BURN_W      = DEFAULT_BURN_W
);

  localparam int IDX_W = $clog2(NUM_CANDLES);
  localparam int CNT_W = $clog2(NUM_CANDLES + 1);

  logic                   set_enable;
  logic [IDX_W-1:0]       pos_to_set;
  logic                   clear_enable;
  logic [IDX_W-1:0]       pos_to_clear;
  logic [BURN_W-1:0]      burn_time;
  logic                   tick_en;
  logic [NUM_CANDLES-1:0] candle_state;
  logic [NUM_CANDLES-1:0] burnout;
  logic [CNT_W-1:0]       lit_count;
  logic                   all_out;

  modport master (
    output set_enable, pos_to_set, clear_enable, pos_to_clear, burn_time, tick_en,
    input  candle_state, burnout, lit_count, all_out
  );

  modport slave (
    input  set_enable, pos_to_set, clear_enable, pos_to_clear, burn_time, tick_en,
    output candle_state, burnout, lit_count, all_out
  );

endinterface

// File: rtl/candle_slot.sv
// One candle: lit flag, optional burn timer and burnout pulse.
// Burn timers are built only when CANDLE_BURNOUT_EN is defined.
module candle_slot
  import candle_pkg::*;
#(
  parameter int BURN_W = DEFAULT_BURN_W
) (
  input  logic              clk,
  input  logic              clr_sync,
  input  logic              set_cmd,
  input  logic              clr_cmd,
  input  logic [BURN_W-1:0] burn_time,
  input  logic              tick_en,
  output logic              lit,
  output logic              burnout
);

  logic clear_wins;
  logic lit_d;

  assign clear_wins = clr_cmd && (CMD_CLEAR_PRIORITY || !set_cmd);

`ifdef CANDLE_BURNOUT_EN
  localparam logic [BURN_W-1:0] TIMER_ONE = BURN_W'(1);

  logic [BURN_W-1:0] timer_q;
  logic [BURN_W-1:0] timer_d;
  logic              burnout_d;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    lit_d     = lit;
    timer_d   = timer_q;
    burnout_d = 1'b0;
    if (clear_wins) begin
      lit_d   = 1'b0;
      timer_d = '0;
    end else if (set_cmd) begin
      lit_d   = 1'b1;
      timer_d = burn_time;
    end else if (lit && tick_en && (timer_q != '0)) begin
      // A zero timer means burn forever, so only non-zero timers count down.
      timer_d = timer_q - TIMER_ONE;
      if (timer_q == TIMER_ONE) begin
        lit_d     = 1'b0;
        burnout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every slot updates from pre-edge values.
    if (clr_sync) begin
      lit     <= 1'b0;
      timer_q <= '0;
      burnout <= 1'b0;
    end else begin
      lit     <= lit_d;
      timer_q <= timer_d;
      burnout <= burnout_d;
    end
  end
`else
  logic unused_timer_inputs;
  assign unused_timer_inputs = ^{burn_time, tick_en};
  assign burnout             = 1'b0;

  always_comb begin
    lit_d = lit;
    if (clear_wins) begin
      lit_d = 1'b0;
    end else if (set_cmd) begin
      lit_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_sync) begin
      lit <= 1'b0;
    end else begin
      lit <= lit_d;
    end
  end
`endif

endmodule

// File: rtl/candle_bank_controller.sv
// Bank of NUM_CANDLES candles: index decode, range gating, lit count and all_out.
// Optional burn timers are enabled by defining CANDLE_BURNOUT_EN.
module candle_bank_controller
  import candle_pkg::*;
#(
  parameter int NUM_CANDLES = DEFAULT_NUM_CANDLES,
  parameter int BURN_W      = DEFAULT_BURN_W
) (
  input  logic                     sys_clk,
  input  logic                     clr_sync,
  candle_bank_controller_if.slave  bus
);

  localparam int                IDX_W = $clog2(NUM_CANDLES);
  localparam int                CNT_W = $clog2(NUM_CANDLES + 1);
  localparam logic [IDX_W:0]    LIMIT = (IDX_W + 1)'(NUM_CANDLES);

  logic                   set_ok;
  logic                   clr_ok;
  logic [NUM_CANDLES-1:0] lit_vec;
  logic [NUM_CANDLES-1:0] burnout_vec;
  logic [CNT_W-1:0]       count;

  // Out-of-range indices only matter when NUM_CANDLES is not a power of two.
  assign set_ok = bus.set_enable   && ({1'b0, bus.pos_to_set}   < LIMIT);
  assign clr_ok = bus.clear_enable && ({1'b0, bus.pos_to_clear} < LIMIT);

  for (genvar g = 0; g < NUM_CANDLES; g++) begin : g_slot
    candle_slot #(
      .BURN_W (BURN_W)
    ) u_slot (
      .clk       (sys_clk),
      .clr_sync  (clr_sync),
      .set_cmd   (set_ok && (bus.pos_to_set   == IDX_W'(g))),
      .clr_cmd   (clr_ok && (bus.pos_to_clear == IDX_W'(g))),
      .burn_time (bus.burn_time),
      .tick_en   (bus.tick_en),
      .lit       (lit_vec[g]),
      .burnout   (burnout_vec[g])
    );
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_CANDLES; i++) begin
      count = count + CNT_W'(lit_vec[i]);
    end
  end

  assign bus.candle_state = lit_vec;
  assign bus.burnout      = burnout_vec;
  assign bus.lit_count    = count;
  assign bus.all_out      = (lit_vec == '0);

endmodule

// File: tb/tb_candle_bank_controller.sv
// Scoreboard bench for candle_bank_controller: an 8-candle and a 5-candle instance
// run side by side; expectations adapt to whether CANDLE_BURNOUT_EN is defined.
module tb_candle_bank_controller;

  localparam int N8 = 8;
  localparam int N5 = 5;
  localparam int BW = 8;
`ifdef CANDLE_BURNOUT_EN
  localparam bit BURN_EN = 1'b1;
`else
  localparam bit BURN_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] state;
    logic [7:0] bo;
    int         cnt;
    logic       all_out;
  } exp_t;

  logic sys_clk  = 1'b0;
  logic clr_sync = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t q8[$];
  exp_t q5[$];
  bit   m_lit[2][8];
  int   m_tmr[2][8];

  always #5 sys_clk = ~sys_clk;

  candle_bank_controller_if #(.NUM_CANDLES(N8), .BURN_W(BW)) b8 ();
  candle_bank_controller_if #(.NUM_CANDLES(N5), .BURN_W(BW)) b5 ();

  candle_bank_controller #(.NUM_CANDLES(N8), .BURN_W(BW)) dut8 (
    .sys_clk  (sys_clk),
    .clr_sync (clr_sync),
    .bus      (b8.slave)
  );

  candle_bank_controller #(.NUM_CANDLES(N5), .BURN_W(BW)) dut5 (
    .sys_clk  (sys_clk),
    .clr_sync (clr_sync),
    .bus      (b5.slave)
  );

  // Behavioural reference: what the bank holds after the coming edge.
  task automatic model(input int d, input int n, input logic se, input int sp,
                       input logic ce, input int cp, input int bt, input logic tk,
                       output exp_t e);
    logic s;
    logic c;
    e.state = '0;
    e.bo    = '0;
    e.cnt   = 0;
    for (int i = 0; i < n; i++) begin
      s = se && (sp < n) && (sp == i);
      c = ce && (cp < n) && (cp == i);
      if (clr_sync) begin
        m_lit[d][i] = 1'b0;
        m_tmr[d][i] = 0;
      end else if (c) begin
        m_lit[d][i] = 1'b0;
        m_tmr[d][i] = 0;
      end else if (s) begin
        m_lit[d][i] = 1'b1;
        m_tmr[d][i] = BURN_EN ? bt : 0;
      end else if (BURN_EN && m_lit[d][i] && tk && (m_tmr[d][i] > 0)) begin
        m_tmr[d][i] = m_tmr[d][i] - 1;
        if (m_tmr[d][i] == 0) begin
          m_lit[d][i] = 1'b0;
          e.bo[i]     = 1'b1;
        end
      end
      e.state[i] = m_lit[d][i];
      if (m_lit[d][i]) e.cnt++;
    end
    e.all_out = (e.cnt == 0);
  endtask

  // Push expectations for both banks, clock once, pop and compare.
  task automatic cycle(input string tag);
    exp_t e;
    model(0, N8, b8.set_enable, int'(b8.pos_to_set), b8.clear_enable,
          int'(b8.pos_to_clear), int'(b8.burn_time), b8.tick_en, e);
    q8.push_back(e);
    model(1, N5, b5.set_enable, int'(b5.pos_to_set), b5.clear_enable,
          int'(b5.pos_to_clear), int'(b5.burn_time), b5.tick_en, e);
    q5.push_back(e);
    @(posedge sys_clk);
    #1;
    e = q8.pop_front();
    checks += 4;
    if (b8.candle_state !== e.state) begin
      $display("FAIL %s n8 candle_state got %h want %h", tag, b8.candle_state, e.state); failures++;
    end
    if (b8.burnout !== e.bo) begin
      $display("FAIL %s n8 burnout got %h want %h", tag, b8.burnout, e.bo); failures++;
    end
    if (b8.lit_count !== 4'(e.cnt)) begin
      $display("FAIL %s n8 lit_count got %0d want %0d", tag, b8.lit_count, e.cnt); failures++;
    end
    if (b8.all_out !== e.all_out) begin
      $display("FAIL %s n8 all_out got %b want %b", tag, b8.all_out, e.all_out); failures++;
    end
    e = q5.pop_front();
    checks += 4;
    if (b5.candle_state !== e.state[4:0]) begin
      $display("FAIL %s n5 candle_state got %h want %h", tag, b5.candle_state, e.state[4:0]); failures++;
    end
    if (b5.burnout !== e.bo[4:0]) begin
      $display("FAIL %s n5 burnout got %h want %h", tag, b5.burnout, e.bo[4:0]); failures++;
    end
    if (b5.lit_count !== 3'(e.cnt)) begin
      $display("FAIL %s n5 lit_count got %0d want %0d", tag, b5.lit_count, e.cnt); failures++;
    end
    if (b5.all_out !== e.all_out) begin
      $display("FAIL %s n5 all_out got %b want %b", tag, b5.all_out, e.all_out); failures++;
    end
  endtask

  task automatic idle();
    b8.set_enable = 1'b0; b8.pos_to_set = '0; b8.clear_enable = 1'b0;
    b8.pos_to_clear = '0; b8.burn_time = '0; b8.tick_en = 1'b0;
    b5.set_enable = 1'b0; b5.pos_to_set = '0; b5.clear_enable = 1'b0;
    b5.pos_to_clear = '0; b5.burn_time = '0; b5.tick_en = 1'b0;
  endtask

  task automatic pulse_reset();
    idle();
    clr_sync = 1'b1;
    cycle("reset_pulse");
    clr_sync = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    clr_sync = 1'b1;
    b8.set_enable = 1'b1; b8.pos_to_set = 3'd3;
    b5.set_enable = 1'b1; b5.pos_to_set = 3'd1;
    repeat (3) cycle("reset_hold");
    checks += 3;
    if (b8.candle_state !== 8'h00) begin
      $display("FAIL reset_state got %h want 00", b8.candle_state); failures++;
    end
    if (b8.all_out !== 1'b1) begin
      $display("FAIL reset_all_out got %b want 1", b8.all_out); failures++;
    end
    if (b8.lit_count !== 4'd0) begin
      $display("FAIL reset_lit_count got %0d want 0", b8.lit_count); failures++;
    end
    clr_sync = 1'b0;
    b5.set_enable = 1'b0;
    cycle("first_set");
    idle();
    checks += 2;
    if (b8.candle_state !== 8'h08) begin
      $display("FAIL first_set_state got %h want 08", b8.candle_state); failures++;
    end
    if (b8.lit_count !== 4'd1) begin
      $display("FAIL first_set_count got %0d want 1", b8.lit_count); failures++;
    end
  endtask

  task automatic test_set_clear();
    b8.set_enable = 1'b1; b8.pos_to_set = 3'd5;
    cycle("set5");
    idle();
    checks++;
    if (b8.candle_state !== 8'h28) begin
      $display("FAIL set5_state got %h want 28", b8.candle_state); failures++;
    end
    b8.clear_enable = 1'b1; b8.pos_to_clear = 3'd3;
    cycle("clear3");
    idle();
    checks++;
    if (b8.candle_state !== 8'h20) begin
      $display("FAIL clear3_state got %h want 20", b8.candle_state); failures++;
    end
    b8.set_enable = 1'b1; b8.pos_to_set = 3'd2;
    b8.clear_enable = 1'b1; b8.pos_to_clear = 3'd2;
    cycle("set_clear_same");
    idle();
    checks++;
    if (b8.candle_state !== 8'h20) begin
      $display("FAIL set_clear_same_state got %h want 20", b8.candle_state); failures++;
    end
  endtask

  task automatic test_burn_timer();
    b8.set_enable = 1'b1; b8.pos_to_set = 3'd1; b8.burn_time = 8'd3;
    cycle("burn_set1");
    idle();
    b8.tick_en = 1'b1;
    repeat (3) cycle("burn_tick");
    checks += 2;
    if (b8.candle_state[1] !== !BURN_EN) begin
      $display("FAIL burn_bit1 got %b want %b", b8.candle_state[1], !BURN_EN); failures++;
    end
    if (b8.burnout !== (BURN_EN ? 8'h02 : 8'h00)) begin
      $display("FAIL burn_pulse got %h want %h", b8.burnout, BURN_EN ? 8'h02 : 8'h00); failures++;
    end
    cycle("burn_tick4");
    idle();
    checks++;
    if (b8.burnout !== 8'h00) begin
      $display("FAIL burn_tick4_pulse got %h want 00", b8.burnout); failures++;
    end
  endtask

  task automatic test_relight();
    pulse_reset();
    b8.set_enable = 1'b1; b8.burn_time = 8'd2;
    b8.pos_to_set = 3'd0; cycle("relight_set0");
    b8.pos_to_set = 3'd4; cycle("relight_set4");
    b8.pos_to_set = 3'd6; cycle("relight_set6");
    idle();
    b8.tick_en = 1'b1; cycle("relight_tick1");
    idle();
    b8.set_enable = 1'b1; b8.pos_to_set = 3'd4; b8.burn_time = 8'd2;
    cycle("relight4");
    idle();
    b8.tick_en = 1'b1; b8.clear_enable = 1'b1; b8.pos_to_clear = 3'd6;
    cycle("relight_tick2");
    checks += 2;
    if (b8.candle_state !== (BURN_EN ? 8'h10 : 8'h11)) begin
      $display("FAIL tick2_state got %h want %h", b8.candle_state, BURN_EN ? 8'h10 : 8'h11); failures++;
    end
    if (b8.burnout !== (BURN_EN ? 8'h01 : 8'h00)) begin
      $display("FAIL tick2_pulse got %h want %h", b8.burnout, BURN_EN ? 8'h01 : 8'h00); failures++;
    end
    idle();
    b8.tick_en = 1'b1;
    cycle("relight_tick3");
    idle();
    checks += 2;
    if (b8.candle_state !== (BURN_EN ? 8'h00 : 8'h11)) begin
      $display("FAIL tick3_state got %h want %h", b8.candle_state, BURN_EN ? 8'h00 : 8'h11); failures++;
    end
    if (b8.burnout !== (BURN_EN ? 8'h10 : 8'h00)) begin
      $display("FAIL tick3_pulse got %h want %h", b8.burnout, BURN_EN ? 8'h10 : 8'h00); failures++;
    end
    cycle("relight_quiet");
  endtask

  task automatic test_range_n5();
    pulse_reset();
    b5.set_enable = 1'b1; b5.pos_to_set = 3'd2;
    cycle("n5_set2");
    b5.pos_to_set = 3'd6; b5.clear_enable = 1'b1; b5.pos_to_clear = 3'd2;
    cycle("n5_oor_set");
    idle();
    checks++;
    if (b5.candle_state !== 5'h00) begin
      $display("FAIL n5_oor_set_state got %h want 00", b5.candle_state); failures++;
    end
    b5.set_enable = 1'b1; b5.pos_to_set = 3'd1;
    b5.clear_enable = 1'b1; b5.pos_to_clear = 3'd7;
    cycle("n5_oor_clear");
    idle();
    b5.set_enable = 1'b1; b5.pos_to_set = 3'd5;
    cycle("n5_set5");
    checks++;
    if (b5.candle_state !== 5'h02) begin
      $display("FAIL n5_oor_state got %h want 02", b5.candle_state); failures++;
    end
    for (int i = 0; i < N5; i++) begin
      b5.pos_to_set = 3'(i);
      cycle("n5_fill");
    end
    idle();
    checks += 3;
    if (b5.lit_count !== 3'd5) begin
      $display("FAIL n5_full_count got %0d want 5", b5.lit_count); failures++;
    end
    if (b5.candle_state !== 5'h1f) begin
      $display("FAIL n5_full_state got %h want 1f", b5.candle_state); failures++;
    end
    if (b5.all_out !== 1'b0) begin
      $display("FAIL n5_full_all_out got %b want 0", b5.all_out); failures++;
    end
  endtask

  task automatic test_reset_mid_burn();
    pulse_reset();
    b8.set_enable = 1'b1; b8.pos_to_set = 3'd1; b8.burn_time = 8'd2;
    cycle("mid_set1");
    idle();
    b8.tick_en = 1'b1;
    cycle("mid_tick");
    clr_sync = 1'b1;
    b8.set_enable = 1'b1; b8.pos_to_set = 3'd1; b8.burn_time = 8'd2;
    cycle("mid_reset");
    checks += 2;
    if (b8.candle_state !== 8'h00) begin
      $display("FAIL mid_reset_state got %h want 00", b8.candle_state); failures++;
    end
    if (b8.burnout !== 8'h00) begin
      $display("FAIL mid_reset_pulse got %h want 00", b8.burnout); failures++;
    end
    clr_sync = 1'b0;
    idle();
    b8.tick_en = 1'b1;
    cycle("mid_after");
    idle();
    checks++;
    if (b8.burnout !== 8'h00) begin
      $display("FAIL mid_after_pulse got %h want 00", b8.burnout); failures++;
    end
  endtask

  task automatic test_long_burn();
    logic seen;
    b8.set_enable = 1'b1; b8.pos_to_set = 3'd2; b8.burn_time = 8'd7;
    cycle("long_set2");
    idle();
    b8.tick_en = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      cycle("long_tick");
      seen = seen | (|b8.burnout);
    end
    idle();
    checks += 2;
    if (b8.candle_state[2] !== !BURN_EN) begin
      $display("FAIL long_bit2 got %b want %b", b8.candle_state[2], !BURN_EN); failures++;
    end
    if (seen !== BURN_EN) begin
      $display("FAIL long_pulse_seen got %b want %b", seen, BURN_EN); failures++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set_clear();
    test_burn_timer();
    test_relight();
    test_range_n5();
    test_reset_mid_burn();
    test_long_burn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/candle_bank_controller.md
Name: candle_bank_controller

Overview:
Parametrised successor to the 8-candle set/clear controller. Holds NUM_CANDLES candle on/off bits and accepts independent indexed set (light) and clear (extinguish) commands each cycle. Each lit candle carries a burn timer that extinguishes it automatically after a programmable number of tick_en strobes. Sits between the user command decoder and the LED/display driver, and reports the lit count and burnout events.

Parameters:
NUM_CANDLES, 8, number of candle slots (2..64; need not be a power of 2)
BURN_W, 8, burn timer width in bits
IDX_W, $clog2(NUM_CANDLES), index width (derived, not overridden)

Ports:
sys_clk  input  1  system clock, rising edge
clr_sync  input  1  synchronous active-high reset
set_enable  input  1  light candle pos_to_set this cycle
pos_to_set  input  IDX_W  index to light
clear_enable  input  1  extinguish candle pos_to_clear this cycle
pos_to_clear  input  IDX_W  index to extinguish
burn_time  input  BURN_W  timer load value used on set; 0 = burn forever
tick_en  input  1  burn timer decrement strobe
candle_state  output  NUM_CANDLES  registered lit bits, bit i = candle i
burnout  output  NUM_CANDLES  registered one-cycle pulse, bit i = candle i expired by timer
lit_count  output  $clog2(NUM_CANDLES+1)  popcount of candle_state, combinational from the register
all_out  output  1  high when candle_state == 0

Behaviour:
- Reset: clr_sync sampled high at a rising edge -> candle_state=0, all timers=0, burnout=0; lit_count=0 and all_out=1 follow. Reset overrides every command in the same cycle. A command issued in the cycle after reset deasserts is accepted.
- Latency: commands take effect at the next rising edge. candle_state updates 1 cycle after the command. lit_count and all_out update in the same cycle as candle_state.
- Set: set_enable && pos_to_set < NUM_CANDLES -> bit goes to 1 and the timer loads burn_time. Setting an already-lit candle relights it and reloads the timer.
- Clear: clear_enable && pos_to_clear < NUM_CANDLES -> bit goes to 0 and the timer goes to 0. Clearing an unlit candle has no effect.
- Out-of-range index (>= NUM_CANDLES): that command is ignored and the other command still executes.
- Set and clear to the same index in one cycle: clear wins, candle ends unlit. Set and clear to different indices: both execute.
- Timer, per lit candle with timer > 0 on a tick_en cycle: timer decrements. On the 1->0 transition the candle goes unlit and burnout[i] pulses high for exactly the next cycle.
- Timer = 0 on a lit candle (loaded burn_time = 0): the candle never expires.
- Set on the same candle in the same cycle as tick_en: the set (load) wins and there is no decrement that cycle.
- Clear in the same cycle as an expiring tick: the candle is cleared and burnout is not pulsed.
- Multiple candles may expire in the same cycle; each raises its own burnout bit.
- Unlit candles ignore tick_en.

Optional Feature:
CANDLE_BURNOUT_EN:
- Defined: burn timers, burnout and tick_en behave as above.
- Undefined: no timer registers are built. Candles stay lit until cleared. burnout is tied to 0. burn_time and tick_en are ignored, but the ports remain so the interface is unchanged.

Decomposition:
- Package candle_pkg: default NUM_CANDLES and BURN_W localparams, the CMD_CLEAR_PRIORITY decision documented as a constant, and a slot status struct {lit, timer}.
- One sub-module, candle_slot: per-candle lit flag, timer, set/clear/tick priority and burnout pulse. It is generated NUM_CANDLES times.
- The top level holds index decode, out-of-range gating, popcount and all_out.

Test Plan:
- Reset hold, then release -> candle_state=8'h00, all_out=1, lit_count=0; set pos 3 with burn_time=0 -> candle_state=8'h08 one cycle later, lit_count=1.
- Set 3 then set 5, clear 3 -> 8'h08, 8'h28, 8'h20 on consecutive cycles; set+clear pos 2 in the same cycle -> state stays 8'h20.
- Set pos 1 with burn_time=3, then 3 tick_en strobes -> bit 1 drops after the 3rd tick and burnout=8'h02 for exactly one cycle; a 4th tick produces no pulse.
- Set pos 0 and pos 4 with burn_time=2, relight pos 4 after the 1st tick -> pos 0 expires at tick 2, pos 4 at tick 3; clear pos 6 on an expiring tick -> no burnout bit 6.
- NUM_CANDLES=5: set pos 6 with clear pos 2 in the same cycle -> set ignored, clear executes; lit_count width 3; all 5 lit -> lit_count=5.
- clr_sync asserted mid-burn with set_enable high -> state 0, timers 0, no burnout pulse; build without CANDLE_BURNOUT_EN -> candle stays lit through 300 ticks, burnout remains 0.
